// File: rtl/debug_port_pkg.sv
// Shared types and constants for the debug-port arbiter: FSM state encoding
// and the frame geometry (word width, byte count, ID/sequence field widths).
package debug_port_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ID,
        ST_DATA,
        ST_GAP
    } state_t;

    localparam int         DATA_BYTES    = 6;
    localparam int         WORD_W        = 48;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         ID_SRC_W      = 4;
    localparam int         SEQ_W         = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: combinational search upward from the last winner,
// with the winner pointer updated only when the caller accepts the grant.
module rr_arbiter
    import debug_port_pkg::*;
#(
    parameter int NUM_SRC = 4
)
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_SRC-1:0]  i_req,
    input  logic                i_update,
    output logic [ID_SRC_W-1:0] o_grant,
    output logic                o_grant_valid
);

    localparam logic [2*NUM_SRC-1:0] ROT_LSB = {{(2*NUM_SRC-1){1'b0}}, 1'b1};

    logic [ID_SRC_W-1:0]  r_last_grant;
    logic [2*NUM_SRC-1:0] w_rot;
    int                   w_start;
    int                   w_idx;

    // Rotate requests so bit 0 is the source just after the last winner; the
    // descending loop leaves the lowest rotated position as the final winner.
    always_comb begin
        w_start = int'(r_last_grant) + 1;
        if (w_start >= NUM_SRC) begin
            w_start = 0;
        end
        w_rot         = {i_req, i_req} >> w_start;
        w_idx         = 0;
        o_grant       = '0;
        o_grant_valid = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if ((w_rot & (ROT_LSB << i)) != '0) begin
                w_idx = w_start + i;
                if (w_idx >= NUM_SRC) begin
                    w_idx = w_idx - NUM_SRC;
                end
                o_grant       = ID_SRC_W'(w_idx);
                o_grant_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= ID_SRC_W'(NUM_SRC - 1);
        end else if (i_update) begin
            r_last_grant <= o_grant;
        end
    end

endmodule

// File: rtl/debug_port_arbiter.sv
// Shares the 8-bit debug port between NUM_SRC 48-bit sources: grants one
// round-robin, then sends SYNC, ID and six data bytes (LSB first) with a strobe.
module debug_port_arbiter
    import debug_port_pkg::*;
#(
    parameter int         NUM_SRC    = 4,
    parameter int         GAP_CYCLES = 2,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
)
(
    input  logic                      CLK_1MHZ,
    input  logic                      RESET,
    input  logic                      ENABLE,
    input  logic [NUM_SRC-1:0]        SRC_REQ,
    input  logic [NUM_SRC*WORD_W-1:0] SRC_DATA,
    output logic [NUM_SRC-1:0]        SRC_ACK,
    output logic [7:0]                D_OUT,
    output logic                      D_STROBE,
    output logic                      FRAME_ACTIVE
);

    localparam logic [NUM_SRC-1:0] ACK_LSB  = NUM_SRC'(1);
    localparam logic [7:0]         GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [2:0]         BYTE_LAST = 3'(DATA_BYTES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_d_out;
    logic                  r_strobe;
    logic                  r_active;
    logic [NUM_SRC-1:0]    r_ack;
    logic [SEQ_W-1:0]      r_seq;
    logic [ID_SRC_W-1:0]   r_id;
    logic [WORD_W-1:0]     r_shift;
    logic [2:0]            r_byte_cnt;
    logic [7:0]            r_gap_cnt;

    logic [7:0]            w_d_nxt;
    logic                  w_strobe_nxt;
    logic                  w_active_nxt;
    logic [NUM_SRC-1:0]    w_ack_nxt;
    logic [2:0]            w_byte_cnt_nxt;
    logic [7:0]            w_gap_cnt_nxt;
    logic                  w_take;
    logic [ID_SRC_W-1:0]   w_grant;
    logic                  w_grant_valid;
    logic [WORD_W-1:0]     w_word;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_rr (
        .i_clk         (CLK_1MHZ),
        .i_rst         (RESET),
        .i_req         (SRC_REQ),
        .i_update      (w_take),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );

    assign w_word = WORD_W'(SRC_DATA >> (WORD_W * int'(w_grant)));

    // Outputs are computed for the state being entered and registered with it.
    always_comb begin
        w_state_nxt    = r_state;
        w_d_nxt        = 8'h00;
        w_strobe_nxt   = 1'b0;
        w_active_nxt   = 1'b0;
        w_ack_nxt      = '0;
        w_byte_cnt_nxt = r_byte_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_take         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ENABLE && w_grant_valid) begin
                    w_take       = 1'b1;
                    w_state_nxt  = ST_SYNC;
                    w_d_nxt      = SYNC_BYTE;
                    w_strobe_nxt = 1'b1;
                    w_active_nxt = 1'b1;
                    w_ack_nxt    = ACK_LSB << w_grant;
                end
            end
            ST_SYNC: begin
                w_state_nxt  = ST_ID;
                w_d_nxt      = {r_seq, r_id};
                w_strobe_nxt = 1'b1;
                w_active_nxt = 1'b1;
            end
            ST_ID: begin
                w_state_nxt    = ST_DATA;
                w_d_nxt        = r_shift[7:0];
                w_strobe_nxt   = 1'b1;
                w_active_nxt   = 1'b1;
                w_byte_cnt_nxt = 3'd0;
            end
            ST_DATA: begin
                if (r_byte_cnt == BYTE_LAST) begin
                    if (GAP_CYCLES == 0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt   = ST_GAP;
                        w_active_nxt  = 1'b1;
                        w_gap_cnt_nxt = 8'd0;
                    end
                end else begin
                    w_d_nxt        = r_shift[7:0];
                    w_strobe_nxt   = 1'b1;
                    w_active_nxt   = 1'b1;
                    w_byte_cnt_nxt = r_byte_cnt + 3'd1;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_active_nxt  = 1'b1;
                    w_gap_cnt_nxt = r_gap_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_1MHZ) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_d_out    <= 8'h00;
            r_strobe   <= 1'b0;
            r_active   <= 1'b0;
            r_ack      <= '0;
            r_seq      <= '0;
            r_byte_cnt <= 3'd0;
            r_gap_cnt  <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_d_out    <= w_d_nxt;
            r_strobe   <= w_strobe_nxt;
            r_active   <= w_active_nxt;
            r_ack      <= w_ack_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            if (r_state == ST_ID) begin
                r_seq <= r_seq + 1'b1;
            end
        end
    end

    // Frame payload: latched once at grant, then drained one byte per cycle.
    always_ff @(posedge CLK_1MHZ) begin
        if (w_take) begin
            r_shift <= w_word;
            r_id    <= w_grant;
        end else if (r_state == ST_ID || r_state == ST_DATA) begin
            r_shift <= r_shift >> 8;
        end
    end

    assign D_OUT        = r_d_out;
    assign D_STROBE     = r_strobe;
    assign FRAME_ACTIVE = r_active;
    assign SRC_ACK      = r_ack;

endmodule

// File: tb/tb_debug_port_arbiter.sv
// Directed bench for debug_port_arbiter: one instance with a 2-cycle gap and
// one with no gap, driven from a vector table plus multi-frame sequences.
module tb_debug_port_arbiter;

    localparam logic [47:0] W0 = 48'h665544332211;
    localparam logic [47:0] W1 = 48'hC1C2C3C4C5C6;
    localparam logic [47:0] W2 = 48'h0F1E2D3C4B5A;
    localparam logic [47:0] W3 = 48'hDEADBEEF0123;

    typedef struct {
        logic [3:0] req;
        logic       en;
        logic [7:0] d;
        logic       stb;
        logic       fa;
        logic [3:0] ack;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [3:0]   req_a, req_b;
    logic [191:0] data_a, data_b;
    logic [3:0]   ack_a, ack_b;
    logic [7:0]   d_a, d_b;
    logic         stb_a, stb_b, fa_a, fa_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    debug_port_arbiter #(.NUM_SRC(4), .GAP_CYCLES(2), .SYNC_BYTE(8'hA5)) dut_a (
        .CLK_1MHZ(clk), .RESET(rst), .ENABLE(en), .SRC_REQ(req_a), .SRC_DATA(data_a),
        .SRC_ACK(ack_a), .D_OUT(d_a), .D_STROBE(stb_a), .FRAME_ACTIVE(fa_a)
    );

    debug_port_arbiter #(.NUM_SRC(4), .GAP_CYCLES(0), .SYNC_BYTE(8'hA5)) dut_b (
        .CLK_1MHZ(clk), .RESET(rst), .ENABLE(en), .SRC_REQ(req_b), .SRC_DATA(data_b),
        .SRC_ACK(ack_b), .D_OUT(d_b), .D_STROBE(stb_b), .FRAME_ACTIVE(fa_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    // Waits (bounded) for the next strobe, then captures 8 bytes packed LSB-first.
    task automatic get_frame(input bit sel, input int mut_at, input string tag,
                             output logic [63:0] fr, output int lows);
        logic s;
        bit   found;
        int   nstb;
        found = 1'b0;
        fr    = '0;
        lows  = 0;
        nstb  = 0;
        for (int n = 0; n < 60 && !found; n++) begin
            tick;
            s = sel ? stb_b : stb_a;
            if (s) found = 1'b1;
            else lows++;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s_start: no strobe within 60 cycles", tag);
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (k > 0) tick;
                s = sel ? stb_b : stb_a;
                if (s) nstb++;
                fr = fr | (64'(sel ? d_b : d_a) << (8 * k));
                if (k == mut_at) begin
                    data_a = ~data_a;
                    data_b = ~data_b;
                end
            end
            chk({tag, "_strobe_len"}, 64'(nstb), 64'd8);
        end
    endtask

    vec_t        tv[12];
    logic [63:0] fr;
    int          lows;
    int          nstb;
    logic [3:0]  ackv;

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        req_a  = 4'b0000;
        req_b  = 4'b0000;
        data_a = {W3, W2, W1, W0};
        data_b = {W3, W2, W1, W0};

        tv[0]  = '{req: 4'b0001, en: 1'b1, d: 8'hA5, stb: 1'b1, fa: 1'b1, ack: 4'b0001};
        tv[1]  = '{req: 4'b0000, en: 1'b1, d: 8'h00, stb: 1'b1, fa: 1'b1, ack: 4'b0000};
        tv[2]  = '{req: 4'b0000, en: 1'b1, d: 8'h11, stb: 1'b1, fa: 1'b1, ack: 4'b0000};
        tv[3]  = '{req: 4'b0000, en: 1'b1, d: 8'h22, stb: 1'b1, fa: 1'b1, ack: 4'b0000};
        tv[4]  = '{req: 4'b0000, en: 1'b1, d: 8'h33, stb: 1'b1, fa: 1'b1, ack: 4'b0000};
        tv[5]  = '{req: 4'b0000, en: 1'b1, d: 8'h44, stb: 1'b1, fa: 1'b1, ack: 4'b0000};
        tv[6]  = '{req: 4'b0000, en: 1'b1, d: 8'h55, stb: 1'b1, fa: 1'b1, ack: 4'b0000};
        tv[7]  = '{req: 4'b0000, en: 1'b1, d: 8'h66, stb: 1'b1, fa: 1'b1, ack: 4'b0000};
        tv[8]  = '{req: 4'b0000, en: 1'b1, d: 8'h00, stb: 1'b0, fa: 1'b1, ack: 4'b0000};
        tv[9]  = '{req: 4'b0000, en: 1'b1, d: 8'h00, stb: 1'b0, fa: 1'b1, ack: 4'b0000};
        tv[10] = '{req: 4'b0000, en: 1'b1, d: 8'h00, stb: 1'b0, fa: 1'b0, ack: 4'b0000};
        tv[11] = '{req: 4'b0000, en: 1'b1, d: 8'h00, stb: 1'b0, fa: 1'b0, ack: 4'b0000};

        // Reset state
        tick;
        tick;
        chk("rst_d", 64'(d_a), 64'h00);
        chk("rst_stb", 64'(stb_a), 64'd0);
        chk("rst_fa", 64'(fa_a), 64'd0);
        chk("rst_ack", 64'(ack_a), 64'd0);
        rst = 1'b0;

        // Single request from source 0, cycle by cycle
        for (int i = 0; i < 12; i++) begin
            req_a = tv[i].req;
            en    = tv[i].en;
            tick;
            chk($sformatf("vec%0d_d", i), 64'(d_a), 64'(tv[i].d));
            chk($sformatf("vec%0d_stb", i), 64'(stb_a), 64'(tv[i].stb));
            chk($sformatf("vec%0d_fa", i), 64'(fa_a), 64'(tv[i].fa));
            chk($sformatf("vec%0d_ack", i), 64'(ack_a), 64'(tv[i].ack));
        end

        // All four sources continuously: rotation and minimum spacing
        req_a = 4'b1111;
        en    = 1'b1;
        do_reset;
        get_frame(1'b0, -1, "rr0", fr, lows);
        chk("rr0_frame", fr, {W0, 8'h00, 8'hA5});
        get_frame(1'b0, -1, "rr1", fr, lows);
        chk("rr1_frame", fr, {W1, 8'h11, 8'hA5});
        chk("rr1_gap", 64'(lows), 64'd3);
        get_frame(1'b0, -1, "rr2", fr, lows);
        chk("rr2_frame", fr, {W2, 8'h22, 8'hA5});
        chk("rr2_gap", 64'(lows), 64'd3);
        get_frame(1'b0, -1, "rr3", fr, lows);
        chk("rr3_frame", fr, {W3, 8'h33, 8'hA5});
        chk("rr3_gap", 64'(lows), 64'd3);
        get_frame(1'b0, -1, "rr4", fr, lows);
        chk("rr4_frame", fr, {W0, 8'h40, 8'hA5});
        chk("rr4_gap", 64'(lows), 64'd3);

        // Reset while data byte 3 is on the port
        nstb = 0;
        for (int n = 0; n < 40 && nstb == 0; n++) begin
            tick;
            if (stb_a) nstb = 1;
        end
        chk("abort_found_frame", 64'(nstb), 64'd1);
        for (int k = 0; k < 5; k++) tick;
        chk("abort_pre_d", 64'(d_a), 64'(W1[31:24]));
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_d", 64'(d_a), 64'h00);
        chk("abort_stb", 64'(stb_a), 64'd0);
        chk("abort_ack", 64'(ack_a), 64'd0);
        chk("abort_fa", 64'(fa_a), 64'd0);
        get_frame(1'b0, -1, "abort_next", fr, lows);
        chk("abort_next_frame", fr, {W0, 8'h00, 8'hA5});

        // ENABLE gating, then ENABLE dropped mid-frame
        en    = 1'b0;
        req_a = 4'b0100;
        do_reset;
        nstb = 0;
        for (int n = 0; n < 10; n++) begin
            tick;
            if (stb_a) nstb++;
        end
        chk("en0_no_strobe", 64'(nstb), 64'd0);
        en   = 1'b1;
        nstb = 0;
        fr   = '0;
        ackv = '0;
        for (int n = 0; n < 20; n++) begin
            tick;
            if (stb_a) begin
                fr = fr | (64'(d_a) << (8 * nstb));
                if (nstb == 0) ackv = ack_a;
                nstb++;
                if (nstb == 3) en = 1'b0;
            end
        end
        chk("en_drop_strobes", 64'(nstb), 64'd8);
        chk("en_drop_frame", fr, {W2, 8'h02, 8'hA5});
        chk("en_drop_ack", 64'(ackv), 64'(4'b0100));

        // Sequence nibble wraps after 16 frames from source 1
        en    = 1'b1;
        req_a = 4'b0010;
        do_reset;
        for (int k = 0; k < 17; k++) begin
            get_frame(1'b0, -1, $sformatf("seq%0d", k), fr, lows);
            chk($sformatf("seq%0d_frame", k), fr, {W1, 4'(k), 4'h1, 8'hA5});
            if (k > 0) chk($sformatf("seq%0d_gap", k), 64'(lows), 64'd3);
        end

        // Zero-gap instance: one idle cycle between frames, word latched at grant
        req_a = 4'b0000;
        req_b = 4'b1000;
        do_reset;
        get_frame(1'b1, -1, "g0_f0", fr, lows);
        chk("g0_f0_frame", fr, {W3, 8'h03, 8'hA5});
        get_frame(1'b1, 4, "g0_f1", fr, lows);
        chk("g0_f1_frame", fr, {W3, 8'h13, 8'hA5});
        chk("g0_f1_gap", 64'(lows), 64'd1);
        get_frame(1'b1, -1, "g0_f2", fr, lows);
        chk("g0_f2_frame", fr, {~W3, 8'h23, 8'hA5});
        chk("g0_f2_gap", 64'(lows), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
